// File: rtl/dca_step_inst_gen.sv
// Step instruction generator for a blocked matrix engine.
// One command describes an R x C grid of output tiles, each reduced over
// K blocks. Steps come out row-major over tiles with k innermost. Each tile
// may start with an accumulator-load step. The last k step of a tile
// carries LSU2_REQ and store_last.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The producer keeps its payload stable and valid high until the transfer,
// except on clear or reset. The same rule applies to cmd_* (cmd_valid and
// cmd_ready) and to step_inst (step_inst_valid and step_inst_ready).
module dca_step_inst_gen #(
    parameter int BW_BLK_IDX   = 8,
    parameter int BW_STEP_INST = 5 + 3 * BW_BLK_IDX + 1
) (
    input  logic                    clk,
    input  logic                    rstnn,
    input  logic                    clear,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [BW_BLK_IDX-1:0]   cmd_num_row_m1,
    input  logic [BW_BLK_IDX-1:0]   cmd_num_col_m1,
    input  logic [BW_BLK_IDX-1:0]   cmd_num_k_m1,
    input  logic                    cmd_load_acc,
    output logic                    step_inst_valid,
    input  logic                    step_inst_ready,
    output logic [BW_STEP_INST-1:0] step_inst,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LDACC   = 2'd1,
        ST_COMPUTE = 2'd2
    } state_t;

    localparam logic [BW_BLK_IDX-1:0] IDX_ONE = 1;
    localparam logic [4:0] OP_LDACC   = 5'b10001;  // NO_CAL | LOAD_ACC
    localparam logic [4:0] OP_COMPUTE = 5'b00110;  // LSU0_REQ | LSU1_REQ
    localparam logic [4:0] OP_LSU2    = 5'b01000;

    state_t                  state, nxt_state;
    logic [BW_BLK_IDX-1:0]   num_row_m1, num_col_m1, num_k_m1;
    logic [BW_BLK_IDX-1:0]   nxt_num_row_m1, nxt_num_col_m1, nxt_num_k_m1;
    logic                    load_acc, nxt_load_acc;
    logic [BW_BLK_IDX-1:0]   row_idx, col_idx, k_idx;
    logic [BW_BLK_IDX-1:0]   nxt_row_idx, nxt_col_idx, nxt_k_idx;
    logic                    nxt_done;
    logic                    nxt_valid;
    logic [4:0]              nxt_opcode;
    logic                    nxt_store_last;
    logic [BW_STEP_INST-1:0] nxt_step_inst;

    // Done is high for one cycle. A new command is not taken in that cycle.
    assign cmd_ready = (state == ST_IDLE) && !done;
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    // Next state, index advance and the step that the next cycle will offer.
    always_comb begin
        nxt_state      = state;
        nxt_num_row_m1 = num_row_m1;
        nxt_num_col_m1 = num_col_m1;
        nxt_num_k_m1   = num_k_m1;
        nxt_load_acc   = load_acc;
        nxt_row_idx    = row_idx;
        nxt_col_idx    = col_idx;
        nxt_k_idx      = k_idx;
        nxt_done       = 1'b0;
        nxt_valid      = 1'b0;
        nxt_opcode     = 5'b00000;
        nxt_store_last = 1'b0;
        nxt_step_inst  = '0;

        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    nxt_num_row_m1 = cmd_num_row_m1;
                    nxt_num_col_m1 = cmd_num_col_m1;
                    nxt_num_k_m1   = cmd_num_k_m1;
                    nxt_load_acc   = cmd_load_acc;
                    nxt_row_idx    = '0;
                    nxt_col_idx    = '0;
                    nxt_k_idx      = '0;
                    nxt_state      = cmd_load_acc ? ST_LDACC : ST_COMPUTE;
                end
            end
            ST_LDACC: begin
                if (step_inst_ready) begin
                    nxt_state = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (step_inst_ready) begin
                    if (k_idx != num_k_m1) begin
                        nxt_k_idx = k_idx + IDX_ONE;
                    end else begin
                        // The tile is finished, so move on to the next tile.
                        nxt_k_idx = '0;
                        nxt_state = load_acc ? ST_LDACC : ST_COMPUTE;
                        if (col_idx != num_col_m1) begin
                            nxt_col_idx = col_idx + IDX_ONE;
                        end else begin
                            nxt_col_idx = '0;
                            if (row_idx != num_row_m1) begin
                                nxt_row_idx = row_idx + IDX_ONE;
                            end else begin
                                nxt_row_idx = '0;
                                nxt_state   = ST_IDLE;
                                nxt_done    = 1'b1;
                            end
                        end
                    end
                end
            end
            default: nxt_state = ST_IDLE;
        endcase

        // Clear wins over everything, including an accept in the same cycle.
        if (clear) begin
            nxt_state = ST_IDLE;
            nxt_done  = 1'b0;
        end

        case (nxt_state)
            ST_LDACC: begin
                nxt_valid     = 1'b1;
                nxt_opcode    = OP_LDACC;
                nxt_step_inst = {{BW_BLK_IDX{1'b0}}, nxt_col_idx, nxt_row_idx,
                                 1'b0, nxt_opcode};
            end
            ST_COMPUTE: begin
                nxt_valid  = 1'b1;
                nxt_opcode = OP_COMPUTE;
                if (nxt_k_idx == nxt_num_k_m1) begin
                    nxt_opcode     = OP_COMPUTE | OP_LSU2;
                    nxt_store_last = 1'b1;
                end
                nxt_step_inst = {nxt_k_idx, nxt_col_idx, nxt_row_idx,
                                 nxt_store_last, nxt_opcode};
            end
            default: begin
                nxt_valid     = 1'b0;
                nxt_step_inst = '0;
            end
        endcase
    end

    // FSM state, latched command, indices and the registered step outputs.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state           <= ST_IDLE;
            num_row_m1      <= '0;
            num_col_m1      <= '0;
            num_k_m1        <= '0;
            load_acc        <= 1'b0;
            row_idx         <= '0;
            col_idx         <= '0;
            k_idx           <= '0;
            step_inst_valid <= 1'b0;
            step_inst       <= '0;
            done            <= 1'b0;
        end else begin
            state           <= nxt_state;
            num_row_m1      <= nxt_num_row_m1;
            num_col_m1      <= nxt_num_col_m1;
            num_k_m1        <= nxt_num_k_m1;
            load_acc        <= nxt_load_acc;
            row_idx         <= nxt_row_idx;
            col_idx         <= nxt_col_idx;
            k_idx           <= nxt_k_idx;
            step_inst_valid <= nxt_valid;
            step_inst       <= nxt_step_inst;
            done            <= nxt_done;
        end
    end

endmodule

// File: tb/tb_dca_step_inst_gen.sv
// Bench for dca_step_inst_gen. A reference model expands each command into
// its expected step list with nested loops. The bench then streams the DUT
// output against that list under fixed or random consumer backpressure.
module tb_dca_step_inst_gen;

    localparam int BW = 8;
    localparam int SW = 5 + 3 * BW + 1;

    logic          clk;
    logic          rstnn;
    logic          clear;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [BW-1:0] cmd_num_row_m1;
    logic [BW-1:0] cmd_num_col_m1;
    logic [BW-1:0] cmd_num_k_m1;
    logic          cmd_load_acc;
    logic          step_inst_valid;
    logic          step_inst_ready;
    logic [SW-1:0] step_inst;
    logic          busy;
    logic          done;
    logic [1:0]    state_dbg;

    int total;
    int bad;
    logic [SW-1:0] exp_q[$];

    dca_step_inst_gen #(.BW_BLK_IDX(BW), .BW_STEP_INST(SW)) dut (
        .clk             (clk),
        .rstnn           (rstnn),
        .clear           (clear),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_num_row_m1  (cmd_num_row_m1),
        .cmd_num_col_m1  (cmd_num_col_m1),
        .cmd_num_k_m1    (cmd_num_k_m1),
        .cmd_load_acc    (cmd_load_acc),
        .step_inst_valid (step_inst_valid),
        .step_inst_ready (step_inst_ready),
        .step_inst       (step_inst),
        .busy            (busy),
        .done            (done),
        .state_dbg       (state_dbg)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: tiles in row-major order, with k innermost per tile.
    task automatic build_exp(input int rm, input int cm, input int km, input bit la);
        exp_q.delete();
        for (int r = 0; r <= rm; r++) begin
            for (int c = 0; c <= cm; c++) begin
                if (la) exp_q.push_back({BW'(0), BW'(c), BW'(r), 1'b0, 5'b10001});
                for (int k = 0; k <= km; k++) begin
                    if (k == km) exp_q.push_back({BW'(k), BW'(c), BW'(r), 1'b1, 5'b01110});
                    else         exp_q.push_back({BW'(k), BW'(c), BW'(r), 1'b0, 5'b00110});
                end
            end
        end
    endtask

    // Drives one command. The bench is at a negedge on entry and on exit.
    task automatic drive_cmd(input int rm, input int cm, input int km, input bit la);
        cmd_num_row_m1 = BW'(rm);
        cmd_num_col_m1 = BW'(cm);
        cmd_num_k_m1   = BW'(km);
        cmd_load_acc   = la;
        cmd_valid      = 1'b1;
        @(negedge clk);
        cmd_valid      = 1'b0;
    endtask

    // Runs a full command and checks every step, stall, done and re-accept.
    // mode 0 keeps ready high; mode 1 drives ready randomly.
    task automatic run_cmd(input int rm, input int cm, input int km, input bit la,
                           input int mode);
        logic [SW-1:0] prev_step;
        logic [SW-1:0] exp;
        bit prev_stall;
        bit last_acc;
        bit rdy;
        bit finished;
        build_exp(rm, cm, km, la);
        prev_stall = 1'b0;
        last_acc   = 1'b0;
        finished   = 1'b0;
        prev_step  = '0;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
        end
        drive_cmd(rm, cm, km, la);
        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            total++;
            if (done !== last_acc) begin
                bad++;
                $display("FAIL done_timing: got %b want %b (cyc %0d)", done, last_acc, cyc);
            end
            if (last_acc) begin
                total++;
                if (cmd_ready !== 1'b0 || busy !== 1'b0 || step_inst_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL done_cycle: ready=%b busy=%b valid=%b want 0 0 0",
                             cmd_ready, busy, step_inst_valid);
                end
                // A command offered during the done cycle must not be taken.
                cmd_num_row_m1 = BW'($urandom);
                cmd_num_col_m1 = BW'($urandom);
                cmd_num_k_m1   = BW'($urandom);
                cmd_load_acc   = 1'($urandom);
                cmd_valid      = 1'b1;
                step_inst_ready = 1'b0;
                @(negedge clk);
                cmd_valid = 1'b0;
                total++;
                if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL after_done: done=%b ready=%b busy=%b want 0 1 0",
                             done, cmd_ready, busy);
                end
                finished = 1'b1;
            end else begin
                if (prev_stall) begin
                    total++;
                    if (step_inst !== prev_step || step_inst_valid !== 1'b1) begin
                        bad++;
                        $display("FAIL stall_hold: got %h/%b want %h/1",
                                 step_inst, step_inst_valid, prev_step);
                    end
                end
                if (exp_q.size() != 0) begin
                    total++;
                    if (step_inst_valid !== 1'b1 || busy !== 1'b1) begin
                        bad++;
                        $display("FAIL valid_no_bubble: valid=%b busy=%b want 1 1",
                                 step_inst_valid, busy);
                    end
                end
                rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                step_inst_ready = rdy;
                // Garbage commands while busy must be ignored.
                cmd_valid = (exp_q.size() > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                cmd_num_row_m1 = BW'($urandom);
                cmd_num_k_m1   = BW'($urandom);
                last_acc = 1'b0;
                if (step_inst_valid && rdy) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL extra_step: got %h want none", step_inst);
                    end else begin
                        exp = exp_q.pop_front();
                        if (step_inst !== exp) begin
                            bad++;
                            $display("FAIL step_value: got %h want %h", step_inst, exp);
                        end
                        if (exp_q.size() == 0) last_acc = 1'b1;
                    end
                end
                prev_stall = step_inst_valid && !rdy;
                prev_step  = step_inst;
                @(negedge clk);
                cmd_valid = 1'b0;
            end
        end
        if (!finished) begin
            total++;
            bad++;
            $display("FAIL cmd_timeout: %0d steps left want 0", exp_q.size());
        end
        step_inst_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstnn = 1'b0;
        #12;
        total++;
        if (cmd_ready !== 1'b1 || step_inst_valid !== 1'b0 || step_inst !== '0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: ready=%b valid=%b step=%h busy=%b done=%b",
                     cmd_ready, step_inst_valid, step_inst, busy, done);
        end
        @(negedge clk);
        rstnn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_step();
        run_cmd(0, 0, 0, 0, 0);
    endtask

    task automatic test_load_acc_seq();
        run_cmd(1, 0, 2, 1, 0);
    endtask

    task automatic test_random_ready();
        run_cmd(1, 0, 2, 1, 1);
        run_cmd(2, 1, 1, 0, 1);
    endtask

    task automatic test_back_to_back();
        run_cmd(0, 2, 3, 0, 0);
        run_cmd(1, 1, 0, 1, 0);
    endtask

    task automatic test_random_cmds();
        for (int i = 0; i < 8; i++) begin
            run_cmd($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), $urandom_range(0, 1));
        end
    endtask

    task automatic test_clear();
        step_inst_ready = 1'b1;
        drive_cmd(1, 1, 1, 1);
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        step_inst_ready = 1'b0;
        total++;
        if (step_inst_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 ||
            done !== 1'b0) begin
            bad++;
            $display("FAIL clear_idle: valid=%b ready=%b busy=%b done=%b want 0 1 0 0",
                     step_inst_valid, cmd_ready, busy, done);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL clear_no_done: got %b want 0", done);
        end
        run_cmd(0, 1, 1, 1, 0);
    endtask

    task automatic test_reset_mid();
        step_inst_ready = 1'b1;
        drive_cmd(2, 2, 2, 0);
        repeat (4) @(negedge clk);
        rstnn = 1'b0;
        #1;
        total++;
        if (step_inst_valid !== 1'b0 || step_inst !== '0 || busy !== 1'b0 ||
            done !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: valid=%b step=%h busy=%b done=%b ready=%b",
                     step_inst_valid, step_inst, busy, done, cmd_ready);
        end
        @(negedge clk);
        rstnn = 1'b1;
        step_inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || step_inst_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_no_done: done=%b valid=%b want 0 0", done, step_inst_valid);
            end
        end
        run_cmd(1, 2, 0, 1, 1);
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        clear           = 1'b0;
        cmd_valid       = 1'b0;
        cmd_num_row_m1  = '0;
        cmd_num_col_m1  = '0;
        cmd_num_k_m1    = '0;
        cmd_load_acc    = 1'b0;
        step_inst_ready = 1'b0;
        test_reset();
        test_single_step();
        test_load_acc_seq();
        test_random_ready();
        test_back_to_back();
        test_random_cmds();
        test_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
